// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Purpose  : Shared constants for the branch-decision block: B-type funct3
//            encodings and the default statistics counter width.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // B-type funct3 encodings (010 and 011 are reserved)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Default width of the optional statistics counters
    localparam int CNT_W_DEFAULT = 32;

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_eval
// Purpose  : Purely combinational decode of funct3 plus ALU flags into the
//            raw branch condition, and flagging of reserved funct3 codes.
//            Each code looks at exactly one flag, so an unknown value on the
//            other flag never reaches cond.
// Revision : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       less,
    output logic       cond,
    output logic       illegal_code
);

    // Select the single relevant flag (and its polarity) for each funct3 code
    always_comb begin
        cond         = 1'b0;
        illegal_code = 1'b0;
        case (funct3)
            F3_BEQ  : cond = zero;
            F3_BNE  : cond = ~zero;
            F3_BLT  : cond = less;
            F3_BGE  : cond = ~less;
            F3_BLTU : cond = less;
            F3_BGEU : cond = ~less;
            default : begin
                // 010 / 011 are reserved: never taken
                cond         = 1'b0;
                illegal_code = 1'b1;
            end
        endcase
    end

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Purpose  : Branch-decision block between the ALU flags and the PC-select
//            mux. pc_src and illegal_branch are combinational; illegal_seen
//            is a sticky registered flag cleared only by rst.
//            Optional feature macro: BRANCH_STATS_EN - when defined, builds
//            wrapping taken/executed branch counters of width CNT_W; when
//            undefined, taken_cnt and branch_cnt are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit
    import branch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             less,
    input  logic             branch,
    output logic             pc_src,
    output logic             illegal_branch,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] branch_cnt
);

    logic w_cond;
    logic w_illegal_code;
    logic r_illegal_seen;

    branch_cond_eval u_cond_eval (
        .funct3       (funct3),
        .zero         (zero),
        .less         (less),
        .cond         (w_cond),
        .illegal_code (w_illegal_code)
    );

    // Gate the raw decode with the control-unit branch flag
    assign pc_src         = branch & w_cond;
    assign illegal_branch = branch & w_illegal_code;

    // Sticky record of any illegal branch; only rst clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_seen <= 1'b0;
        end else if (illegal_branch) begin
            r_illegal_seen <= 1'b1;
        end
    end

    assign illegal_seen = r_illegal_seen;

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_branch_cnt;

    // Free-running wrapping counters of executed and taken branches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_taken_cnt  <= '0;
            r_branch_cnt <= '0;
        end else begin
            if (branch) begin
                r_branch_cnt <= r_branch_cnt + c_one;
            end
            if (pc_src) begin
                r_taken_cnt <= r_taken_cnt + c_one;
            end
        end
    end

    assign taken_cnt  = r_taken_cnt;
    assign branch_cnt = r_branch_cnt;
`else
    // Statistics not built: ports kept so the interface does not change
    assign taken_cnt  = '0;
    assign branch_cnt = '0;
`endif

endmodule : branch_unit
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_unit
// Purpose  : Self-checking bench for branch_unit. The stimulus process pushes
//            the expected response into a queue each cycle; a separate monitor
//            pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [2:0]    funct3;
    logic          zero;
    logic          less;
    logic          branch;
    logic          pc_src;
    logic          illegal_branch;
    logic          illegal_seen;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] branch_cnt;

    branch_unit #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .funct3         (funct3),
        .zero           (zero),
        .less           (less),
        .branch         (branch),
        .pc_src         (pc_src),
        .illegal_branch (illegal_branch),
        .illegal_seen   (illegal_seen),
        .taken_cnt      (taken_cnt),
        .branch_cnt     (branch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          pc;
        logic          ill;
        logic          seen;
        logic [CW-1:0] tc;
        logic [CW-1:0] bc;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: what the DUT registers should hold right now
    int   m_seen = 0;
    int   m_taken = 0;
    int   m_execs = 0;
    // Inputs applied during the current cycle (consumed at the next edge)
    int   p_rst = 1;
    int   p_branch = 0;
    int   p_taken = 0;
    int   p_illegal = 0;

    // Branch rule as stated by the ISA: which flag and polarity per code
    function automatic int ref_taken(input int b, input int f3, input logic z, input logic l);
        int t;
        if (b == 0) return 0;
        if (f3 == 0)      t = (z === 1'b1) ? 1 : 0;
        else if (f3 == 1) t = (z === 1'b0) ? 1 : 0;
        else if (f3 == 4 || f3 == 6) t = (l === 1'b1) ? 1 : 0;
        else if (f3 == 5 || f3 == 7) t = (l === 1'b0) ? 1 : 0;
        else t = 0;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: advance the model across the edge, then drive and predict
    task automatic step(input int r, input int b, input int f3, input logic z, input logic l);
        exp_t e;
        int   t;
        @(posedge clk);
        if (p_rst != 0) begin
            m_seen = 0; m_taken = 0; m_execs = 0;
        end else begin
            if (p_illegal != 0) m_seen = 1;
            m_execs = (m_execs + p_branch) % (1 << CW);
            m_taken = (m_taken + p_taken) % (1 << CW);
        end
        #1;
        rst    = (r != 0);
        branch = (b != 0);
        funct3 = 3'(f3);
        zero   = z;
        less   = l;
        t = ref_taken(b, f3, z, l);
        p_rst     = r;
        p_branch  = b;
        p_taken   = t;
        p_illegal = (b != 0 && (f3 == 2 || f3 == 3)) ? 1 : 0;
        e.pc   = (t != 0);
        e.ill  = (p_illegal != 0);
        e.seen = (m_seen != 0);
`ifdef BRANCH_STATS_EN
        e.tc = CW'(m_taken);
        e.bc = CW'(m_execs);
`else
        e.tc = '0;
        e.bc = '0;
`endif
        q_exp.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest outstanding prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("pc_src",         int'(pc_src),         int'(e.pc));
                chk("illegal_branch", int'(illegal_branch), int'(e.ill));
                chk("illegal_seen",   int'(illegal_seen),   int'(e.seen));
                chk("taken_cnt",      int'(taken_cnt),      int'(e.tc));
                chk("branch_cnt",     int'(branch_cnt),     int'(e.bc));
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; branch = 1'b0; funct3 = 3'd0; zero = 1'b0; less = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // BEQ / BNE
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 0, 1);
        // X on an ignored flag
        step(0, 1, 0, 1, 1'bx);
        step(0, 1, 1, 0, 1'bx);

        // Compare codes with both less values and zero toggled
        for (int f = 4; f < 8; f++) begin
            for (int lv = 0; lv < 2; lv++) begin
                step(0, 1, f, 1'b0, lv[0]);
                step(0, 1, f, 1'b1, lv[0]);
            end
            step(0, 1, f, 1'bx, 1'b1);
        end

        // branch=0 gating sweep
        for (int f = 0; f < 8; f++)
            for (int zz = 0; zz < 2; zz++)
                for (int lv = 0; lv < 2; lv++)
                    step(0, 0, f, zz[0], lv[0]);

        // Illegal codes, sticky flag, then rst clears it
        step(0, 1, 2, 1, 1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 3, 1, 0);
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // 20 taken BEQ cycles (counters wrap past 15)
        for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Reset in a taken/illegal branch cycle: reset wins
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 4, 0, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait
        wait_cyc = 0;
        while (q_exp.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q_exp.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d outstanding, expected 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_branch_unit
`default_nettype wire

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Branch-decision block of the single-cycle RISC-V core, sitting between the ALU flag outputs (zero, less) and the PC-select mux.
- Combinationally decodes B-type funct3 plus ALU flags into pc_src, which selects PC+imm when the branch is taken.
- Adds registered status: illegal-funct3 detection and optional branch statistics counters.
- The ALU has already chosen the signed or unsigned compare for `less`; this block does no comparison itself.

Parameters:
- CNT_W, 32, width of the statistics counters (only used when BRANCH_STATS_EN is defined).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- funct3  input  3  instruction funct3 field.
- zero  input  1  ALU result-is-zero flag (rs1 == rs2).
- less  input  1  ALU less-than flag (signed for BLT/BGE, unsigned for BLTU/BGEU).
- branch  input  1  control-unit flag: current instruction is a conditional branch.
- pc_src  output  1  1 = take branch target; 0 = PC+4. Combinational.
- illegal_branch  output  1  combinational; 1 when branch=1 and funct3 is 010 or 011.
- illegal_seen  output  1  sticky registered flag, set by any cycle with illegal_branch=1.
- taken_cnt  output  CNT_W  taken-branch count (stats only).
- branch_cnt  output  CNT_W  executed-branch count (stats only).

Behaviour:
- pc_src is purely combinational. It settles in the same cycle, with zero clock latency and no dependence on clk/rst.
- Condition by funct3:
  - 000 BEQ: zero.
  - 001 BNE: ~zero.
  - 100 BLT: less.
  - 101 BGE: ~less.
  - 110 BLTU: less.
  - 111 BGEU: ~less.
  - 010, 011: reserved; the condition is 0.
- pc_src = branch & condition.
  - branch=0 forces pc_src=0 for every funct3/zero/less combination.
- Don't-care inputs:
  - zero is ignored for the BLT/BGE/BLTU/BGEU codes.
  - less is ignored for the BEQ/BNE codes.
  - X on an ignored flag must not propagate to pc_src.
- illegal_branch = branch & (funct3 == 010 | funct3 == 011). It is combinational.
- illegal_seen:
  - Reset value 0.
  - Set to 1 on the clock edge after any cycle with illegal_branch=1.
  - Cleared only by rst.
- Reset:
  - rst=1 at a rising edge clears all registered outputs to 0 on that edge.
  - Reset has no effect on pc_src or illegal_branch.
- Reset and event in the same cycle: reset wins; the event is not counted or flagged.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - branch_cnt increments by 1 each cycle with branch=1 (legal or illegal funct3).
  - taken_cnt increments by 1 each cycle with pc_src=1.
  - Both counters reset to 0 and wrap modulo 2^CNT_W with no saturation.
- Undefined:
  - No counter flops are built.
  - taken_cnt and branch_cnt are tied to 0; the ports stay present so the interface is unchanged.

Decomposition:
- Package branch_pkg holds localparams for the funct3 codes: F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
- The default CNT_W also lives in branch_pkg.
- One combinational sub-module, branch_cond_eval:
  - inputs funct3, zero, less;
  - outputs cond and illegal_code.
- The top level holds the branch gating, the sticky flag and the counters.

Test Plan:
- BEQ/BNE, branch=1: funct3=000 zero=1 -> pc_src=1; zero=0 -> 0. funct3=001 zero=1 -> 0; zero=0 -> 1.
- BLT/BGE/BLTU/BGEU, branch=1: less=1 gives pc_src 1/0/1/0 for funct3 100/101/110/111; less=0 gives 0/1/0/1. Toggling zero must not change the result.
- Gating: branch=0, funct3=000, zero=1 -> pc_src=0. Sweep all 8 funct3 values × zero × less with branch=0 -> pc_src always 0.
- Illegal code: branch=1, funct3=010 -> pc_src=0 and illegal_branch=1; illegal_seen=1 after the next edge and stays 1 until rst=1; then 0.
- Stats (BRANCH_STATS_EN, CNT_W=4): 20 consecutive taken BEQ cycles -> taken_cnt=4 (wraps past 15) and branch_cnt=4. Asserting rst in a branch cycle -> both counters 0 at that edge.
